score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter MAX_COMBO, default 8, which is the combo count at which the combo counter saturates.
REQ-002 SHALL have parameter SCORE_MAX, default 1023, which is the score saturation value and SHALL fit in 10 bits.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_start  input  1  start/restart request, level-sampled each cycle.
REQ-006 SHALL have port i_land_valid  input  1  one landing event per cycle asserted.
REQ-007 SHALL have port i_land_perfect  input  1  qualifies i_land_valid: 1 means perfect (centre) landing; ignored when i_land_valid=0.
REQ-008 SHALL have port i_fall  input  1  player missed a platform (game-over event).
REQ-009 SHALL have port o_score  output  10  current game score; feeds the 7-segment score display's i_score.
REQ-010 SHALL have port o_high_score  output  10  best score since reset.
REQ-011 SHALL have port o_combo  output  4  current consecutive-perfect count.
REQ-012 SHALL have port o_state  output  2  00=IDLE, 01=PLAYING, 10=OVER.
REQ-013 SHALL have port o_new_record  output  1  last finished game set a new high score.

Function
REQ-014 SHALL implement FSM states IDLE, PLAYING, OVER; all outputs registered.
REQ-015 IDLE -> PLAYING on i_start=1; same edge clears o_score, o_combo, o_new_record.
REQ-016 PLAYING -> OVER on i_fall=1; i_start SHALL be ignored in PLAYING.
REQ-017 OVER -> PLAYING on i_start=1 with same clears as REQ-015; o_high_score retained.
REQ-018 In PLAYING, i_land_valid=1 & i_land_perfect=0: o_score += 1, o_combo <= 0, visible the next cycle (1-cycle latency).
REQ-019 In PLAYING, i_land_valid=1 & i_land_perfect=1: c = min(o_combo+1, MAX_COMBO); o_combo <= c; o_score += 2*c.
REQ-020 Score addition SHALL be computed at >=11 bits and saturate at SCORE_MAX; never wrap.
REQ-021 i_land_valid held N cycles in PLAYING SHALL count as N landings.
REQ-022 i_land_valid/i_fall in IDLE or OVER SHALL have no effect.
REQ-023 i_fall and i_land_valid in the same PLAYING cycle: fall wins, landing discarded, score unchanged.
REQ-024 On PLAYING->OVER edge: if o_score > o_high_score then o_high_score <= o_score and o_new_record <= 1, else o_new_record <= 0; equal score is not a record.
REQ-025 o_new_record SHALL hold until the next start (REQ-015/017) or reset.
REQ-026 o_score SHALL stay frozen in OVER until restart.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, o_score=0, o_high_score=0, o_combo=0, o_new_record=0, overriding all other inputs.
REQ-028 Reset mid-game SHALL discard the game without updating o_high_score.

Verification
REQ-029 rst, then i_start 1 cycle, 3 normal landings -> o_state=01, o_score=3, o_combo=0.
REQ-030 In PLAYING from 0: 10 consecutive perfect landings -> o_combo sequence 1..8,8,8, o_score=2+4+...+16+16+16=104; then one normal landing -> o_score=105, o_combo=0.
REQ-031 Preload o_score=1020 via landings, perfect landing with c=3 -> o_score=1023 (saturated); further landings keep 1023.
REQ-032 Game 1 score 5 then i_fall -> o_state=10, o_high_score=5, o_new_record=1; restart, score 5, fall -> o_high_score=5, o_new_record=0.
REQ-033 i_fall and i_land_valid together at score 7 -> o_score=7, o_state=10; then land pulses -> no change.
REQ-034 rst asserted in PLAYING at score 40, high score 12 -> next cycle all outputs 0, o_state=00.

Source files
------------

// File: rtl/score_keeper.sv
// Score, combo and high-score tracker for a platform-landing game.
// Three-state game FSM (IDLE / PLAYING / OVER); every output is a register.
module score_keeper #(
  parameter int MAX_COMBO = 8,
  parameter int SCORE_MAX = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_land_valid,
  input  logic       i_land_perfect,
  input  logic       i_fall,
  output logic [9:0] o_score,
  output logic [9:0] o_high_score,
  output logic [3:0] o_combo,
  output logic [1:0] o_state,
  output logic       o_new_record
);

  localparam logic [1:0]  ST_IDLE     = 2'b00;
  localparam logic [1:0]  ST_PLAYING  = 2'b01;
  localparam logic [1:0]  ST_OVER     = 2'b10;
  localparam logic [3:0]  MAX_COMBO_C = 4'(MAX_COMBO);
  localparam logic [10:0] SCORE_MAX_C = 11'(SCORE_MAX);

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [9:0]  score_r;
  logic [9:0]  score_nxt_s;
  logic [9:0]  high_r;
  logic [9:0]  high_nxt_s;
  logic [3:0]  combo_r;
  logic [3:0]  combo_nxt_s;
  logic        new_record_r;
  logic        new_record_nxt_s;
  logic [3:0]  combo_inc_s;
  logic [10:0] land_add_s;
  logic [10:0] land_sum_s;
  logic [9:0]  land_score_s;

  // State register; also holds every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      score_r      <= 10'd0;
      high_r       <= 10'd0;
      combo_r      <= 4'd0;
      new_record_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      score_r      <= score_nxt_s;
      high_r       <= high_nxt_s;
      combo_r      <= combo_nxt_s;
      new_record_r <= new_record_nxt_s;
    end
  end

  // Next-state logic; start is only honoured outside PLAYING
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s = ST_PLAYING;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAYING: begin
        if (i_fall) begin
          state_nxt_s = ST_OVER;
        end else begin
          state_nxt_s = ST_PLAYING;
        end
      end
      ST_OVER: begin
        if (i_start) begin
          state_nxt_s = ST_PLAYING;
        end else begin
          state_nxt_s = ST_OVER;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Landing arithmetic: saturating combo, 11-bit sum clamped to SCORE_MAX
  always_comb begin
    if (combo_r >= MAX_COMBO_C) begin
      combo_inc_s = MAX_COMBO_C;
    end else begin
      combo_inc_s = combo_r + 4'd1;
    end
    if (i_land_perfect) begin
      land_add_s = {6'd0, combo_inc_s, 1'b0};
    end else begin
      land_add_s = 11'd1;
    end
    land_sum_s = {1'b0, score_r} + land_add_s;
    if (land_sum_s > SCORE_MAX_C) begin
      land_score_s = SCORE_MAX_C[9:0];
    end else begin
      land_score_s = land_sum_s[9:0];
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    score_nxt_s      = score_r;
    high_nxt_s       = high_r;
    combo_nxt_s      = combo_r;
    new_record_nxt_s = new_record_r;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (i_start) begin
          score_nxt_s      = 10'd0;
          combo_nxt_s      = 4'd0;
          new_record_nxt_s = 1'b0;
        end else begin
          score_nxt_s      = score_r;
        end
      end
      ST_PLAYING: begin
        // A fall in the same cycle as a landing discards the landing
        if (i_fall) begin
          if (score_r > high_r) begin
            high_nxt_s       = score_r;
            new_record_nxt_s = 1'b1;
          end else begin
            new_record_nxt_s = 1'b0;
          end
        end else if (i_land_valid) begin
          score_nxt_s = land_score_s;
          if (i_land_perfect) begin
            combo_nxt_s = combo_inc_s;
          end else begin
            combo_nxt_s = 4'd0;
          end
        end else begin
          score_nxt_s = score_r;
        end
      end
      default: begin
        score_nxt_s = score_r;
      end
    endcase
  end

  assign o_score      = score_r;
  assign o_high_score = high_r;
  assign o_combo      = combo_r;
  assign o_state      = state_r;
  assign o_new_record = new_record_r;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table plus hand-written
// multi-cycle sequences, with expected outputs queued at drive time.
module tb_score_keeper;

  typedef struct {
    logic       rst;
    logic       st;
    logic       lv;
    logic       lp;
    logic       fl;
    logic [9:0] e_score;
    logic [9:0] e_high;
    logic [3:0] e_combo;
    logic [1:0] e_state;
    logic       e_nr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_land_valid = 1'b0;
  logic       i_land_perfect = 1'b0;
  logic       i_fall = 1'b0;
  logic [9:0] o_score;
  logic [9:0] o_high_score;
  logic [3:0] o_combo;
  logic [1:0] o_state;
  logic       o_new_record;

  int   errors = 0;
  int   checks = 0;
  int   step = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  score_keeper #(.MAX_COMBO(8), .SCORE_MAX(1023)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_land_valid   (i_land_valid),
    .i_land_perfect (i_land_perfect),
    .i_fall         (i_fall),
    .o_score        (o_score),
    .o_high_score   (o_high_score),
    .o_combo        (o_combo),
    .o_state        (o_state),
    .o_new_record   (o_new_record)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic lv,
                              input logic lp, input logic f,
                              input int sc, input int hi, input int cb,
                              input int stt, input int nr);
    vec_t v;
    v.rst = r; v.st = s; v.lv = lv; v.lp = lp; v.fl = f;
    v.e_score = 10'(sc); v.e_high = 10'(hi); v.e_combo = 4'(cb);
    v.e_state = 2'(stt); v.e_nr = 1'(nr);
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic apply(input vec_t v);
    vec_t e;
    rst = v.rst; i_start = v.st; i_land_valid = v.lv;
    i_land_perfect = v.lp; i_fall = v.fl;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", step);
    end else begin
      e = exp_q.pop_front();
      cmp("score", int'(o_score), int'(e.e_score));
      cmp("high_score", int'(o_high_score), int'(e.e_high));
      cmp("combo", int'(o_combo), int'(e.e_combo));
      cmp("state", int'(o_state), int'(e.e_state));
      cmp("new_record", int'(o_new_record), int'(e.e_nr));
    end
    step++;
  endtask

  initial begin
    int pc_score[10] = '{2, 6, 12, 20, 30, 42, 56, 72, 88, 104};
    int pc_combo[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};

    //            rst st lv lp fl  score high combo state nr
    tbl.push_back(mk(1, 0, 0, 0, 0,    0,   0,   0,   0,  0));
    tbl.push_back(mk(0, 0, 1, 1, 0,    0,   0,   0,   0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1,    0,   0,   0,   0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,    0,   0,   0,   1,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,    1,   0,   0,   1,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,    2,   0,   0,   1,  0));
    tbl.push_back(mk(0, 0, 1, 0, 0,    3,   0,   0,   1,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,    3,   0,   0,   1,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1,    3,   3,   0,   2,  1));
    tbl.push_back(mk(0, 0, 1, 0, 0,    3,   3,   0,   2,  1));
    tbl.push_back(mk(0, 1, 0, 0, 0,    0,   3,   0,   1,  0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 1, 1, 0, pc_score[i], 3, pc_combo[i], 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  105,   3,   0,   1,  0));
    tbl.push_back(mk(0, 0, 1, 0, 1,  105, 105,   0,   2,  1));
    tbl.push_back(mk(1, 1, 1, 0, 0,    0,   0,   0,   0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,    0,   0,   0,   1,  0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 0, 1, 0, 0, i, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,    5,   5,   0,   2,  1));
    tbl.push_back(mk(0, 1, 0, 0, 0,    0,   5,   0,   1,  0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 0, 1, 0, 0, i, 5, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,    5,   5,   0,   2,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,    0,   5,   0,   1,  0));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(mk(0, 0, 1, 0, 0, i, 5, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1,    7,   7,   0,   2,  1));
    tbl.push_back(mk(0, 0, 1, 0, 0,    7,   7,   0,   2,  1));
    tbl.push_back(mk(0, 0, 1, 1, 0,    7,   7,   0,   2,  1));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    // Reset mid-game at score 40 with high score 12 discards the game
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 12; i++)
      apply(mk(0, 0, 1, 0, 0, i, 0, 0, 1, 0));
    apply(mk(0, 0, 0, 0, 1, 12, 12, 0, 2, 1));
    apply(mk(0, 1, 0, 0, 0, 0, 12, 0, 1, 0));
    for (int i = 1; i <= 40; i++)
      apply(mk(0, 0, 1, 0, 0, i, 12, 0, 1, 0));
    apply(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0));

    // Saturation at 1023: preload 1014, then perfects 1016, 1020, 1026->1023
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 1014; i++)
      apply(mk(0, 0, 1, 0, 0, i, 0, 0, 1, 0));
    apply(mk(0, 0, 1, 1, 0, 1016, 0, 1, 1, 0));
    apply(mk(0, 0, 1, 1, 0, 1020, 0, 2, 1, 0));
    apply(mk(0, 0, 1, 1, 0, 1023, 0, 3, 1, 0));
    apply(mk(0, 0, 1, 0, 0, 1023, 0, 0, 1, 0));
    apply(mk(0, 0, 1, 1, 0, 1023, 0, 1, 1, 0));
    apply(mk(0, 0, 0, 0, 1, 1023, 1023, 1, 2, 1));
    apply(mk(0, 0, 0, 0, 0, 1023, 1023, 1, 2, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
